sm_result_collector: RTL and testbench



---
 rtl/sm_result_collector_pkg.sv | 17 +
 rtl/fifo.sv | 53 +++++
 rtl/sm_result_collector.sv | 127 ++++++++++++
 tb/tb_sm_result_collector.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_result_collector_pkg.sv
// Shared widths and record layout for the feeder / collector / write-back path.
// Record layout: {id, score, channel}, with channel in bit 0.
package sm_result_collector_pkg;

  localparam int unsigned DEF_ID_WIDTH    = 48;
  localparam int unsigned DEF_SCORE_WIDTH = 16;
  localparam int unsigned DEF_RES_DEPTH   = 4;

  localparam int unsigned CH_BIT    = 0;
  localparam int unsigned SCORE_LSB = 1;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with combinational head; a write while full is accepted
// only when a pop happens in the same cycle.
module fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sm_result_collector.sv
// Collects per-channel scores, pops the matching feeder ID and streams
// {id, score, channel} records through a result FIFO, round-robin across channels.
module sm_result_collector
  import sm_result_collector_pkg::*;
#(
  parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH,
  parameter int unsigned SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int unsigned RES_DEPTH   = DEF_RES_DEPTH,
  parameter int unsigned OUT_WIDTH   = ID_WIDTH + SCORE_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   done0,
  input  logic                   done1,
  input  logic [SCORE_WIDTH-1:0] score0,
  input  logic [SCORE_WIDTH-1:0] score1,
  input  logic [ID_WIDTH-1:0]    id0,
  input  logic [ID_WIDTH-1:0]    id1,
  output logic                   re0,
  output logic                   re1,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [OUT_WIDTH-1:0]   res_data,
  output logic                   busy,
  output logic                   err,
  output logic [15:0]            res_count
);

  localparam int unsigned ID_LSB = SCORE_LSB + SCORE_WIDTH;

  typedef struct packed {
    logic                   valid;
    logic [ID_WIDTH-1:0]    id;
    logic [SCORE_WIDTH-1:0] score;
  } pend_t;

  pend_t                pend0;
  pend_t                pend1;
  chan_e                rr_ptr;
  chan_e                grant;
  logic                 contested;
  logic                 drain0;
  logic                 drain1;
  logic                 cap0;
  logic                 cap1;
  logic                 fifo_wr;
  logic                 fifo_rd;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [OUT_WIDTH-1:0] wr_rec;
  logic [OUT_WIDTH-1:0] head;

  assign fifo_rd = ~fifo_empty & res_ready;

  // A full FIFO still takes a write when the head pops in the same cycle.
  always_comb begin
    grant     = CH0;
    drain0    = 1'b0;
    drain1    = 1'b0;
    contested = pend0.valid & pend1.valid;
    if (~fifo_full | fifo_rd) begin
      if (contested)        grant = rr_ptr;
      else if (pend1.valid) grant = CH1;
      else                  grant = CH0;
      drain0 = pend0.valid & (grant == CH0);
      drain1 = pend1.valid & (grant == CH1);
    end
    fifo_wr = drain0 | drain1;

    wr_rec         = '0;
    wr_rec[CH_BIT] = (grant == CH1);
    if (grant == CH1) begin
      wr_rec[SCORE_LSB +: SCORE_WIDTH] = pend1.score;
      wr_rec[ID_LSB +: ID_WIDTH]       = pend1.id;
    end else begin
      wr_rec[SCORE_LSB +: SCORE_WIDTH] = pend0.score;
      wr_rec[ID_LSB +: ID_WIDTH]       = pend0.id;
    end
  end

  // A pending slot that drains this cycle can capture a new score at the same edge.
  assign cap0 = done0 & (~pend0.valid | drain0);
  assign cap1 = done1 & (~pend1.valid | drain1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend0     <= '0;
      pend1     <= '0;
      rr_ptr    <= CH0;
      re0       <= 1'b0;
      re1       <= 1'b0;
      err       <= 1'b0;
      res_count <= '0;
    end else begin
      if (cap0)        pend0 <= '{valid: 1'b1, id: id0, score: score0};
      else if (drain0) pend0.valid <= 1'b0;
      if (cap1)        pend1 <= '{valid: 1'b1, id: id1, score: score1};
      else if (drain1) pend1.valid <= 1'b0;

      re0 <= cap0;
      re1 <= cap1;

      if ((done0 & ~cap0) | (done1 & ~cap1)) err <= 1'b1;
      if (contested & fifo_wr) rr_ptr <= (grant == CH0) ? CH1 : CH0;
      if (fifo_rd) res_count <= res_count + 1'b1;
    end
  end

  fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (wr_rec),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign res_valid = ~fifo_empty;
  assign res_data  = fifo_empty ? '0 : head;
  assign busy      = pend0.valid | pend1.valid | ~fifo_empty;

endmodule

// File: tb/tb_sm_result_collector.sv
// Self-checking bench for sm_result_collector: directed scenarios plus random
// traffic against a queue-based transaction model.
module tb_sm_result_collector;

  localparam int unsigned IDW = 48;
  localparam int unsigned SW  = 16;
  localparam int unsigned OW  = IDW + SW + 1;

  typedef logic [OW-1:0] rec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           done0, done1;
  logic [SW-1:0]  score0, score1;
  logic [IDW-1:0] id0, id1;
  logic           re0, re1;
  logic           res_valid;
  logic           res_ready;
  logic [OW-1:0]  res_data;
  logic           busy;
  logic           err;
  logic [15:0]    res_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;

  // Reference model state
  rec_t        fq[$];
  bit          pv[2];
  rec_t        pr[2];
  bit          rr;
  bit          m_err;
  logic [15:0] m_cnt;
  bit          m_re[2];

  sm_result_collector dut (
    .clk       (clk),
    .rst       (rst),
    .done0     (done0),
    .done1     (done1),
    .score0    (score0),
    .score1    (score1),
    .id0       (id0),
    .id1       (id1),
    .re0       (re0),
    .re1       (re1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .err       (err),
    .res_count (res_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic rec_t mk(input logic [IDW-1:0] id, input logic [SW-1:0] sc, input logic ch);
    return {id, sc, ch};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    pv[0] = 1'b0; pv[1] = 1'b0;
    rr = 1'b0;
    m_err = 1'b0;
    m_cnt = '0;
    m_re[0] = 1'b0; m_re[1] = 1'b0;
  endtask

  // One clock edge of the collector described in terms of queues.
  task automatic model_edge();
    bit pop, canw;
    int g;
    bit d[2];
    d[0] = done0; d[1] = done1;
    pop  = (fq.size() > 0) && res_ready;
    canw = (fq.size() < 4) || pop;
    g = -1;
    if (canw) begin
      if (pv[0] && pv[1]) begin g = int'(rr); rr = !rr; end
      else if (pv[0]) g = 0;
      else if (pv[1]) g = 1;
    end
    if (pop) begin void'(fq.pop_front()); m_cnt = m_cnt + 16'd1; end
    if (g >= 0) begin fq.push_back(pr[g]); pv[g] = 1'b0; end
    for (int c = 0; c < 2; c++) begin
      m_re[c] = 1'b0;
      if (d[c]) begin
        if (!pv[c]) begin
          pv[c]   = 1'b1;
          pr[c]   = (c == 0) ? mk(id0, score0, 1'b0) : mk(id1, score1, 1'b1);
          m_re[c] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    if (chk_en) begin
      chk("res_valid", res_valid, fq.size() > 0);
      if (fq.size() > 0) chk("res_data", res_data, fq[0]);
      else               chk("res_data_idle", res_data, '0);
      chk("busy", busy, pv[0] || pv[1] || (fq.size() > 0));
      chk("err", err, m_err);
      chk("res_count", res_count, m_cnt);
      chk("re0", re0, m_re[0]);
      chk("re1", re1, m_re[1]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    done0 = 1'b0;
    done1 = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; idle(); res_ready = 1'b0;
    score0 = '0; score1 = '0; id0 = '0; id1 = '0;
    model_reset();
    #2;
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", res_count, 16'd0);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // Single result
    res_ready = 1'b1;
    id0 = 48'hA5; score0 = 16'd37; done0 = 1'b1;
    cycle(); idle();
    chk("single_re0", re0, 1'b1);
    cycle();
    chk("single_re0_pulse", re0, 1'b0);
    chk("single_valid", res_valid, 1'b1);
    chk("single_data", res_data, {48'hA5, 16'd37, 1'b0});
    cycle();
    chk("single_count", res_count, 16'd1);

    // Simultaneous pair, then a second pair served channel 1 first
    id0 = 48'h1; score0 = 16'd10; id1 = 48'h2; score1 = 16'd20;
    done0 = 1'b1; done1 = 1'b1;
    cycle(); idle();
    cycle();
    chk("pair1_first", res_data, {48'h1, 16'd10, 1'b0});
    cycle();
    chk("pair1_second", res_data, {48'h2, 16'd20, 1'b1});
    id0 = 48'h3; score0 = 16'd30; id1 = 48'h4; score1 = 16'd40;
    done0 = 1'b1; done1 = 1'b1;
    cycle(); idle();
    cycle();
    chk("pair2_first", res_data, {48'h4, 16'd40, 1'b1});
    cycle();
    chk("pair2_second", res_data, {48'h3, 16'd30, 1'b0});
    repeat (3) cycle();

    // Backpressure: FIFO fills, both pending registers fill, last two dones drop
    res_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin id0 = 48'h100 + 48'(k); score0 = 16'(k); done0 = 1'b1; end
      else            begin id1 = 48'h100 + 48'(k); score1 = 16'(k); done1 = 1'b1; end
      cycle(); idle();
      cycle();
    end
    chk("bp_err", err, 1'b1);
    chk("bp_busy", busy, 1'b1);
    chk("bp_head", res_data, {48'h100, 16'd0, 1'b0});
    res_ready = 1'b1;
    repeat (8) cycle();
    chk("bp_count", res_count, 16'd11);
    chk("bp_drained", busy, 1'b0);

    // Reset with three records queued
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k % 2 == 0) begin id0 = 48'h200 + 48'(k); done0 = 1'b1; end
      else            begin id1 = 48'h200 + 48'(k); done1 = 1'b1; end
      cycle(); idle();
      cycle();
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("mrst_valid", res_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_err", err, 1'b0);
    chk("mrst_count", res_count, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) cycle();

    // Capture on drain
    res_ready = 1'b1;
    id0 = 48'h55; score0 = 16'd1; done0 = 1'b1;
    cycle();
    id0 = 48'h56; score0 = 16'd2; done0 = 1'b1;
    cycle(); idle();
    chk("cod_err", err, 1'b0);
    repeat (3) cycle();
    chk("cod_count", res_count, 16'd2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      done0  = ($urandom_range(0, 2) == 0);
      done1  = ($urandom_range(0, 2) == 0);
      id0    = IDW'({$urandom, $urandom});
      id1    = IDW'({$urandom, $urandom});
      score0 = SW'($urandom);
      score1 = SW'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    idle(); res_ready = 1'b1;
    repeat (10) cycle();

    // Counter wrap
    apply_reset();
    res_ready = 1'b1;
    chk_en = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      id0 = IDW'(i); score0 = SW'(i); done0 = 1'b1;
      cycle();
    end
    idle();
    repeat (4) cycle();
    chk_en = 1'b1;
    cycle();
    chk("wrap_count", res_count, 16'd1);
    chk("wrap_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
